// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, instruction
// field positions, FSM states and decoded instruction classes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC1,
    ST_EXEC2,
    ST_EXEC3,
    ST_HALT
  } state_t;

  // Illegal opcodes decode to CLS_NOP; the separate illegal flag marks them.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOV,
    CLS_LDI,
    CLS_ADD,
    CLS_SUB,
    CLS_HLT
  } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits the instruction byte into
// an operation class and the two register fields.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output op_class_t  op_class,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic       illegal
);

  logic [3:0] opcode;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];

  // Map the opcode to its class; undefined opcodes behave as NOP.
  always_comb begin
    op_class = CLS_NOP;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_MOV:  op_class = CLS_MOV;
      OP_LDI:  op_class = CLS_LDI;
      OP_ADD:  op_class = CLS_ADD;
      OP_SUB:  op_class = CLS_SUB;
      OP_HLT:  op_class = CLS_HLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control unit. Drives the register file, memory and
// ALU strobes so that exactly one source owns the databus in any cycle.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FETCH     | read opcode at pc (only while run=1), pc += 1
// DECODE    | classify ir; NOP/illegal return to FETCH, HLT goes to HALT
// EXEC1     | MOV copy / LDI immediate load / ADD,SUB rd -> ALU operand A
// EXEC2     | ADD,SUB rs -> ALU operand B
// EXEC3     | ADD,SUB ALU result -> rd
// HALT      | stopped until reset; run ignored
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] in_databus,
  output logic [7:0] pc,
  output logic       mem_enable,
  output logic       load,
  output logic       enable,
  output logic [1:0] in_regselect,
  output logic [1:0] out_regselect,
  output logic       alu_load_a,
  output logic       alu_load_b,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       halted,
  output logic       illegal
);

  state_t     state, state_next;
  logic [7:0] ir;
  op_class_t  op_class;
  logic [1:0] rd, rs;
  logic       dec_illegal;

  logic       ir_load, pc_inc;
  logic       mem_enable_c, load_c, enable_c, alu_load_a_c, alu_load_b_c;
  logic       alu_enable_c, alu_sub_c, halted_c, illegal_c;
  logic [1:0] in_regselect_c, out_regselect_c;

  instr_decode u_decode (
    .ir       (ir),
    .op_class (op_class),
    .rd       (rd),
    .rs       (rs),
    .illegal  (dec_illegal)
  );

  // State, instruction register and program counter; pc wraps mod 256.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      ir    <= 8'h00;
      pc    <= PC_RESET;
    end else begin
      state <= state_next;
      if (ir_load) ir <= in_databus;
      if (pc_inc)  pc <= pc + 8'd1;
    end
  end

  // Next-state and strobe decode; everything but the FETCH mem_enable is
  // a function of state and ir only.
  always_comb begin
    state_next      = state;
    ir_load         = 1'b0;
    pc_inc          = 1'b0;
    mem_enable_c    = 1'b0;
    load_c          = 1'b0;
    enable_c        = 1'b0;
    in_regselect_c  = 2'b00;
    out_regselect_c = 2'b00;
    alu_load_a_c    = 1'b0;
    alu_load_b_c    = 1'b0;
    alu_enable_c    = 1'b0;
    alu_sub_c       = 1'b0;
    halted_c        = 1'b0;
    illegal_c       = 1'b0;
    case (state)
      ST_FETCH: begin
        if (run) begin
          mem_enable_c = 1'b1;
          ir_load      = 1'b1;
          pc_inc       = 1'b1;
          state_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op_class)
          CLS_NOP: begin
            illegal_c  = dec_illegal;
            state_next = ST_FETCH;
          end
          CLS_HLT: state_next = ST_HALT;
          default: state_next = ST_EXEC1;
        endcase
      end
      ST_EXEC1: begin
        state_next = ST_FETCH;
        case (op_class)
          CLS_MOV: begin
            enable_c        = 1'b1;
            out_regselect_c = rs;
            load_c          = 1'b1;
            in_regselect_c  = rd;
          end
          CLS_LDI: begin
            mem_enable_c   = 1'b1;
            load_c         = 1'b1;
            in_regselect_c = rd;
            pc_inc         = 1'b1;
          end
          CLS_ADD, CLS_SUB: begin
            enable_c        = 1'b1;
            out_regselect_c = rd;
            alu_load_a_c    = 1'b1;
            alu_sub_c       = (op_class == CLS_SUB);
            state_next      = ST_EXEC2;
          end
          default: state_next = ST_FETCH;
        endcase
      end
      ST_EXEC2: begin
        enable_c        = 1'b1;
        out_regselect_c = rs;
        alu_load_b_c    = 1'b1;
        alu_sub_c       = (op_class == CLS_SUB);
        state_next      = ST_EXEC3;
      end
      ST_EXEC3: begin
        alu_enable_c   = 1'b1;
        load_c         = 1'b1;
        in_regselect_c = rd;
        alu_sub_c      = (op_class == CLS_SUB);
        state_next     = ST_FETCH;
      end
      ST_HALT: halted_c = 1'b1;
      default: state_next = ST_FETCH;
    endcase
  end

  // Reset forces every strobe low at once, including the run-gated fetch.
  always_comb begin
    mem_enable    = mem_enable_c & ~reset;
    load          = load_c & ~reset;
    enable        = enable_c & ~reset;
    in_regselect  = reset ? 2'b00 : in_regselect_c;
    out_regselect = reset ? 2'b00 : out_regselect_c;
    alu_load_a    = alu_load_a_c & ~reset;
    alu_load_b    = alu_load_b_c & ~reset;
    alu_enable    = alu_enable_c & ~reset;
    alu_sub       = alu_sub_c & ~reset;
    halted        = halted_c & ~reset;
    illegal       = illegal_c & ~reset;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a small program memory feeds the
// databus and every cycle is checked against hand-computed strobe vectors.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] in_databus;
  logic [7:0] pc;
  logic       mem_enable, load, enable;
  logic [1:0] in_regselect, out_regselect;
  logic       alu_load_a, alu_load_b, alu_enable, alu_sub, halted, illegal;

  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  logic [12:0] obs_vec;
  logic        bus_ok;

  control_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .in_databus    (in_databus),
    .pc            (pc),
    .mem_enable    (mem_enable),
    .load          (load),
    .enable        (enable),
    .in_regselect  (in_regselect),
    .out_regselect (out_regselect),
    .alu_load_a    (alu_load_a),
    .alu_load_b    (alu_load_b),
    .alu_enable    (alu_enable),
    .alu_sub       (alu_sub),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  assign obs_vec = {mem_enable, load, enable, in_regselect, out_regselect,
                    alu_load_a, alu_load_b, alu_enable, alu_sub, halted, illegal};
  assign bus_ok  = (int'(mem_enable) + int'(enable) + int'(alu_enable)) <= 1;

  function automatic logic [12:0] v(input logic me, ld, en, input logic [1:0] ins, outs,
                                    input logic la, lb, ae, sub, h, il);
    return {me, ld, en, ins, outs, la, lb, ae, sub, h, il};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input string tag, input logic run_v, input logic rst_v,
                     input logic [7:0] pc_exp, input logic [12:0] vec_exp);
    @(posedge clock);
    #1;
    run   = run_v;
    reset = rst_v;
    #1;
    in_databus = mem[pc];
    @(negedge clock);
    chk({tag, "_pc"}, 16'(pc), 16'(pc_exp));
    chk({tag, "_out"}, 16'(obs_vec), 16'(vec_exp));
    chk({tag, "_bus"}, 16'(bus_ok), 16'd1);
  endtask

  localparam logic [12:0] V0 = 13'd0;

  initial begin
    logic [12:0] vf;
    vf = v(1,0,0,2'd0,2'd0,0,0,0,0,0,0);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h16; mem[1] = 8'h2C; mem[2] = 8'hA5;
    mem[3] = 8'h31; mem[4] = 8'h41; mem[5] = 8'h70;
    mem[6] = 8'h00; mem[7] = 8'h00;
    reset = 1'b0;
    run = 1'b1;
    in_databus = 8'h00;
    #1 reset = 1'b1;

    cyc("rst", 1, 1, 8'h00, V0);
    cyc("rst", 1, 1, 8'h00, V0);
    cyc("first_fetch", 1, 0, 8'h00, vf);

    // MOV r1, r2
    cyc("mov_dec", 1, 0, 8'h01, V0);
    cyc("mov_ex1", 1, 0, 8'h01, v(0,1,1,2'd1,2'd2,0,0,0,0,0,0));
    cyc("mov_next", 1, 0, 8'h01, vf);

    // LDI r3, #A5
    cyc("ldi_dec", 1, 0, 8'h02, V0);
    cyc("ldi_ex1", 1, 0, 8'h02, v(1,1,0,2'd3,2'd0,0,0,0,0,0,0));
    cyc("ldi_next", 1, 0, 8'h03, vf);

    // ADD r0, r1
    cyc("add_dec", 1, 0, 8'h04, V0);
    cyc("add_ex1", 1, 0, 8'h04, v(0,0,1,2'd0,2'd0,1,0,0,0,0,0));
    cyc("add_ex2", 1, 0, 8'h04, v(0,0,1,2'd0,2'd1,0,1,0,0,0,0));
    cyc("add_ex3", 1, 0, 8'h04, v(0,1,0,2'd0,2'd0,0,0,1,0,0,0));
    cyc("sub_fetch", 1, 0, 8'h04, vf);

    // SUB r0, r1
    cyc("sub_dec", 1, 0, 8'h05, V0);
    cyc("sub_ex1", 1, 0, 8'h05, v(0,0,1,2'd0,2'd0,1,0,0,1,0,0));
    cyc("sub_ex2", 1, 0, 8'h05, v(0,0,1,2'd0,2'd1,0,1,0,1,0,0));
    cyc("sub_ex3", 1, 0, 8'h05, v(0,1,0,2'd0,2'd0,0,0,1,1,0,0));
    cyc("ill_fetch", 1, 0, 8'h05, vf);

    // Illegal 0x70, then a run=0 stall at the following fetch
    cyc("ill_dec", 1, 0, 8'h06, v(0,0,0,2'd0,2'd0,0,0,0,0,0,1));
    cyc("stall", 0, 0, 8'h06, V0);
    cyc("stall", 0, 0, 8'h06, V0);
    cyc("resume", 1, 0, 8'h06, vf);
    cyc("nop_dec", 1, 0, 8'h07, V0);

    // NOP run up to 0xFF and wrap; program restarts with ADD r0,r1 then HLT
    mem[0] = 8'h31;
    mem[1] = 8'hF0;
    for (int p = 7; p < 256; p++) begin
      cyc("nop_f", 1, 0, 8'(p), vf);
      cyc("nop_d", 1, 0, 8'(p + 1), V0);
    end

    cyc("wrap_fetch", 1, 0, 8'h00, vf);
    cyc("ab_dec", 1, 0, 8'h01, V0);
    cyc("ab_ex1", 1, 0, 8'h01, v(0,0,1,2'd0,2'd0,1,0,0,0,0,0));
    cyc("ab_ex2", 1, 0, 8'h01, v(0,0,1,2'd0,2'd1,0,1,0,0,0,0));
    reset = 1'b1;
    #1;
    chk("abort_pc", 16'(pc), 16'h0000);
    chk("abort_out", 16'(obs_vec), 16'(V0));
    cyc("abort_hold", 1, 1, 8'h00, V0);
    cyc("re_fetch", 1, 0, 8'h00, vf);
    cyc("re_dec", 1, 0, 8'h01, V0);
    cyc("re_ex1", 1, 0, 8'h01, v(0,0,1,2'd0,2'd0,1,0,0,0,0,0));
    cyc("re_ex2", 1, 0, 8'h01, v(0,0,1,2'd0,2'd1,0,1,0,0,0,0));
    cyc("re_ex3", 1, 0, 8'h01, v(0,1,0,2'd0,2'd0,0,0,1,0,0,0));

    // HLT
    cyc("hlt_fetch", 1, 0, 8'h01, vf);
    cyc("hlt_dec", 1, 0, 8'h02, V0);
    cyc("halt", 1, 0, 8'h02, v(0,0,0,2'd0,2'd0,0,0,0,0,1,0));
    cyc("halt", 0, 0, 8'h02, v(0,0,0,2'd0,2'd0,0,0,0,0,1,0));
    cyc("halt", 1, 0, 8'h02, v(0,0,0,2'd0,2'd0,0,0,0,0,1,0));
    cyc("halt", 0, 0, 8'h02, v(0,0,0,2'd0,2'd0,0,0,0,0,1,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
